// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_BYTES       byte stride between consecutive fetches
//   NOP_INSTR         value presented on out_instruction before anything is popped
//   RESET_PC_DEFAULT  default first fetch address after reset
//   fetch_entry_t     one fetch-buffer entry {pc, instr}
//   align_pc()        clears the byte-offset bits of a redirect target
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset     rising-edge clock, async active-high reset
//   push, push_entry  write one entry (ignored when flush is high)
//   pop            consume the head entry (ignored when empty)
//   flush          empty the buffer; a coincident pop still updates the held value
//   count          number of stored entries
//   head           head entry, or the last popped entry when empty
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 64'h0, instr: NOP_INSTR};

    fetch_entry_t          mem_q [DEPTH];
    fetch_entry_t          mem_d [DEPTH];
    fetch_entry_t          hold_q, hold_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_pop, do_push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    // A push into a full buffer is only taken when the head leaves the same cycle.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        hold_d   = hold_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            hold_d = mem_q[rd_ptr_q];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= EMPTY_ENTRY;
            end
            hold_q   <= EMPTY_ENTRY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one read per cycle when buffer
// credit allows, captures the response one cycle later and hands it to decode.
//   clk, reset        rising-edge clock, async active-high reset
//   imem_address      registered fetch address (fetch_pc)
//   imem_instruction  memory word for the address sampled at the previous edge
//   redirect_valid/target  replace the PC and flush everything in flight
//   out_valid/ready/pc/instruction  valid/ready handshake towards decode
//   misalign_err      one-cycle pulse after a redirect with target[1:0] != 0
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        misalign_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [63:0]   inflight_pc_q, inflight_pc_d;
    logic          misalign_q, misalign_d;

    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic          pop, push, issue;
    fetch_entry_t  push_entry, head;

    assign out_valid = (buf_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !redirect_valid;

    // Entries held plus the one still in flight must leave room, net of this
    // cycle's pop, for the word about to be requested.
    assign credit_used = {1'b0, buf_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));

    assign push_entry = '{pc: inflight_pc_q, instr: imem_instruction};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        misalign_d    = redirect_valid && (redirect_target[1:0] != 2'b00);
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_target);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + 64'(INSTR_BYTES);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 64'h0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head       (head)
    );

    assign imem_address    = fetch_pc_q;
    assign out_pc          = head.pc;
    assign out_instruction = head.instr;
    assign misalign_err    = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        misalign_err;

    int passed = 0;
    int total  = 0;
    int ovf    = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .misalign_err     (misalign_err)
    );

    // Instruction memory: three program words at 0..8, elsewhere 0x1000|addr[11:0].
    function automatic logic [31:0] word_at(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0040_0013;
            64'h4:   return 32'h0020_811B;
            64'h8:   return 32'h4011_1033;
            default: return 32'h0000_1000 | {20'h0, a[11:0]};
        endcase
    endfunction

    always @(posedge clk) imem_instruction <= word_at(imem_address);

    // A push that finds the buffer full without a matching pop is a credit bug.
    always @(negedge clk) begin
        if (!reset && dut.push && !dut.pop && (int'(dut.buf_count) == FIFO_DEPTH))
            ovf++;
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [63:0] tgt;
        logic        v;
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] addr;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic rv, input logic [63:0] tgt,
                       input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic [63:0] addr, input logic mis);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.rv = rv; e.tgt = tgt;
        e.v = v; e.pc = pc; e.ins = ins; e.addr = addr; e.mis = mis;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins, input logic [63:0] addr, input logic mis);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, " out_pc"}, out_pc, pc);
        chk({tag, " out_instruction"}, 64'(out_instruction), 64'(ins));
        chk({tag, " imem_address"}, imem_address, addr);
        chk({tag, " misalign_err"}, 64'(misalign_err), 64'(mis));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: reset release, streaming with out_ready=1
        add(1,1,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,1,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,1,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,0,0,            1,64'h4, 32'h0020811B, 64'hC, 0);
        add(0,1,0,0,            1,64'h8, 32'h40111033, 64'h10,0);
        // T2: six stalled cycles, buffer full with 0,4, address parked at 8
        add(1,0,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,0,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,0,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,0,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,0,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,0,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,0,0,            1,64'h4, 32'h0020811B, 64'hC, 0);
        add(0,1,0,0,            1,64'h8, 32'h40111033, 64'h10,0);
        add(0,1,0,0,            1,64'hC, 32'h0000100C, 64'h14,0);
        // T3: redirect to 0x40 with full buffer
        add(1,0,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,0,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,0,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,0,1,64'h40,       1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,0,0,0,            0,64'h0, NOP,          64'h40,0);
        add(0,0,0,0,            0,64'h0, NOP,          64'h44,0);
        add(0,1,0,0,            1,64'h40,32'h00001040, 64'h48,0);
        add(0,1,0,0,            1,64'h44,32'h00001044, 64'h4C,0);
        // T4/T6: misaligned redirect coinciding with pop and response arrival
        add(1,1,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,1,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,1,1,64'h42,       1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'h40,1);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'h44,0);
        add(0,1,0,0,            1,64'h40,32'h00001040, 64'h48,0);
        add(0,1,0,0,            1,64'h44,32'h00001044, 64'h4C,0);
        // PC wrap past 2^64
        add(1,1,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,1,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,1,1,64'hFFFF_FFFF_FFFF_FFFC, 1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'h0, 0);
        add(0,1,0,0,            1,64'hFFFF_FFFF_FFFF_FFFC, 32'h00001FFC, 64'h4, 0);
        add(0,1,0,0,            1,64'h0, 32'h00400013, 64'h8, 0);
        // Back-to-back redirects: last wins, second is misaligned
        add(1,1,0,0,            0,64'h0, NOP,          64'h0, 0);
        add(0,1,0,0,            0,64'h0, NOP,          64'h4, 0);
        add(0,1,1,64'h100,      1,64'h0, 32'h00400013, 64'h8, 0);
        add(0,1,1,64'h201,      0,64'h0, 32'h00400013, 64'h100,0);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'h200,1);
        add(0,1,0,0,            0,64'h0, 32'h00400013, 64'h204,0);
        add(0,1,0,0,            1,64'h200,32'h00001200,64'h208,0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            else step();
            out_ready       = vecs[i].rdy;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].ins,
                    vecs[i].addr, vecs[i].mis);
        end

        // T5: asynchronous reset mid-stream, between clock edges
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        step(); step(); step();
        chk_all("t5_pre", 1'b1, 64'h4, 32'h0020811B, 64'hC, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk_all("t5_async", 1'b0, 64'h0, NOP, 64'h0, 1'b0);
        step();
        reset = 1'b0;
        chk_all("t5_k0", 1'b0, 64'h0, NOP, 64'h0, 1'b0);
        step();
        chk_all("t5_k1", 1'b0, 64'h0, NOP, 64'h4, 1'b0);
        step();
        chk_all("t5_k2", 1'b1, 64'h0, 32'h00400013, 64'h8, 1'b0);
        step();
        chk_all("t5_k3", 1'b1, 64'h4, 32'h0020811B, 64'hC, 1'b0);

        step();
        chk("no_overflow", 64'(ovf), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
